// File: rtl/cmos_capture_pkg.sv
// Shared types and constants for the DVP camera capture block.
// CAP_TEST_PATTERN_EN selects the colour-bar table below as the pixel source.
package cmos_capture_pkg;

  localparam int CAP_H_ACTIVE    = 1280;
  localparam int CAP_V_ACTIVE    = 720;
  localparam int CAP_SKIP_FRAMES = 10;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACTIVE = 2'd2
  } cap_state_t;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_colour(input logic [2:0] bar);
    case (bar)
      3'd0:    return RGB_WHITE;
      3'd1:    return RGB_YELLOW;
      3'd2:    return RGB_CYAN;
      3'd3:    return RGB_GREEN;
      3'd4:    return RGB_MAGENTA;
      3'd5:    return RGB_RED;
      3'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/cmos_capture_if.sv
// Camera DVP bus in, RGB565 pixel stream out, plus FSM state for observation.
// Stream semantics: pixel/pixel_sop/pixel_eop are meaningful only in a cycle
// with pixel_vld=1; pixel_vld is a one-cycle strobe with no ready/backpressure,
// so the sink must take every pixel in the cycle it is offered.
interface cmos_capture_if;
  logic                           capture_en;
  logic                           cam_vsync;
  logic                           cam_href;
  logic [7:0]                     cam_data;
  logic [15:0]                    pixel;
  logic                           pixel_vld;
  logic                           pixel_sop;
  logic                           pixel_eop;
  logic                           frame_done;
  logic                           frame_err;
  cmos_capture_pkg::cap_state_t   state_dbg;

  modport slave (
    input  capture_en, cam_vsync, cam_href, cam_data,
    output pixel, pixel_vld, pixel_sop, pixel_eop, frame_done, frame_err, state_dbg
  );

  modport master (
    output capture_en, cam_vsync, cam_href, cam_data,
    input  pixel, pixel_vld, pixel_sop, pixel_eop, frame_done, frame_err, state_dbg
  );
endinterface

// File: rtl/cmos_capture.sv
// DVP camera receiver: skips settle frames, packs byte pairs into RGB565,
// clips oversize lines/frames and reports per-frame errors.
// Build option CAP_TEST_PATTERN_EN replaces pixel data with colour bars.
module cmos_capture
  import cmos_capture_pkg::*;
#(
  parameter int H_ACTIVE    = CAP_H_ACTIVE,
  parameter int V_ACTIVE    = CAP_V_ACTIVE,
  parameter int SKIP_FRAMES = CAP_SKIP_FRAMES
) (
  input  logic          clk,
  input  logic          rst_n,
  cmos_capture_if.slave bus
);

  localparam logic [10:0] H_CNT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_CNT    = 11'(V_ACTIVE);
  localparam logic [10:0] H_LAST   = 11'(H_ACTIVE - 1);
  localparam logic [10:0] V_LAST   = 11'(V_ACTIVE - 1);
  localparam logic [3:0]  SKIP_CNT = 4'(SKIP_FRAMES);

  cap_state_t  state_q, state_d;
  logic        vs_r_q, vs_r_d, vs_r1_q, vs_r1_d;
  logic        href_r_q, href_r_d, href_r1_q, href_r1_d;
  logic [7:0]  data_r_q, data_r_d, hi_q, hi_d;
  logic [3:0]  settle_cnt_q, settle_cnt_d;
  logic [10:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic        phase_q, phase_d, err_q, err_d;
  logic [15:0] pixel_q, pixel_d;
  logic        vld_q, vld_d, sop_q, sop_d, eop_q, eop_d;
  logic        done_q, done_d, ferr_q, ferr_d;
  logic        vs_rise, vs_fall, href_fall;

  assign vs_rise   = ~vs_r1_q & vs_r_q;
  assign vs_fall   = vs_r1_q & ~vs_r_q;
  assign href_fall = href_r1_q & ~href_r_q;

  // Next-state: input sampling, settle/wait/active sequencing, pixel packing.
  always_comb begin
    vs_r_d       = bus.cam_vsync;
    vs_r1_d      = vs_r_q;
    href_r_d     = bus.cam_href;
    href_r1_d    = href_r_q;
    data_r_d     = bus.cam_data;
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    x_cnt_d      = x_cnt_q;
    y_cnt_d      = y_cnt_q;
    phase_d      = phase_q;
    hi_d         = hi_q;
    err_d        = err_q;
    pixel_d      = pixel_q;
    vld_d        = 1'b0;
    sop_d        = 1'b0;
    eop_d        = 1'b0;
    done_d       = 1'b0;
    ferr_d       = ferr_q;
    case (state_q)
      ST_SETTLE: begin
        if (settle_cnt_q >= SKIP_CNT) state_d = ST_WAIT;
        else if (vs_rise)             settle_cnt_d = settle_cnt_q + 4'd1;
      end
      ST_WAIT: begin
        // capture_en only matters at the frame boundary.
        if (vs_fall && bus.capture_en) begin
          state_d = ST_ACTIVE;
          x_cnt_d = '0;
          y_cnt_d = '0;
          err_d   = 1'b0;
          phase_d = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (href_r_q) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            hi_d = data_r_q;
          end else begin
            if (x_cnt_q < H_CNT && y_cnt_q < V_CNT) begin
              vld_d = 1'b1;
`ifdef CAP_TEST_PATTERN_EN
              pixel_d = bar_colour(x_cnt_q[10:8]);
`else
              pixel_d = {hi_q, data_r_q};
`endif
              sop_d = (x_cnt_q == '0) && (y_cnt_q == '0);
              eop_d = (x_cnt_q == H_LAST) && (y_cnt_q == V_LAST);
            end else begin
              err_d = 1'b1;
            end
            // Saturate so a runaway line cannot wrap back into range.
            if (x_cnt_q != '1) x_cnt_d = x_cnt_q + 11'd1;
          end
        end else begin
          phase_d = 1'b0;
          if (href_fall) begin
            if (x_cnt_q != H_CNT || phase_q) err_d = 1'b1;
            if (x_cnt_q != '0 && y_cnt_q != '1) y_cnt_d = y_cnt_q + 11'd1;
            x_cnt_d = '0;
          end
        end
        // Frame check sees the line close above when both land together.
        if (vs_rise) begin
          done_d  = 1'b1;
          ferr_d  = err_d | (y_cnt_d != V_CNT);
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_SETTLE;
    endcase
  end

  // State and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SETTLE;
      vs_r_q       <= 1'b0;
      vs_r1_q      <= 1'b0;
      href_r_q     <= 1'b0;
      href_r1_q    <= 1'b0;
      data_r_q     <= '0;
      hi_q         <= '0;
      settle_cnt_q <= '0;
      x_cnt_q      <= '0;
      y_cnt_q      <= '0;
      phase_q      <= 1'b0;
      err_q        <= 1'b0;
      pixel_q      <= '0;
      vld_q        <= 1'b0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      done_q       <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_r_q       <= vs_r_d;
      vs_r1_q      <= vs_r1_d;
      href_r_q     <= href_r_d;
      href_r1_q    <= href_r1_d;
      data_r_q     <= data_r_d;
      hi_q         <= hi_d;
      settle_cnt_q <= settle_cnt_d;
      x_cnt_q      <= x_cnt_d;
      y_cnt_q      <= y_cnt_d;
      phase_q      <= phase_d;
      err_q        <= err_d;
      pixel_q      <= pixel_d;
      vld_q        <= vld_d;
      sop_q        <= sop_d;
      eop_q        <= eop_d;
      done_q       <= done_d;
      ferr_q       <= ferr_d;
    end
  end

  assign bus.pixel      = pixel_q;
  assign bus.pixel_vld  = vld_q;
  assign bus.pixel_sop  = sop_q;
  assign bus.pixel_eop  = eop_q;
  assign bus.frame_done = done_q;
  assign bus.frame_err  = ferr_q;
  assign bus.state_dbg  = state_q;

endmodule
